// File: rtl/integer_retirement_scoreboard_pkg.sv
// Shared control package: TIA opcodes plus latency-class definitions used by the
// retirement scoreboard and any issue logic that needs the same latency view.
package integer_retirement_scoreboard_pkg;

    localparam int unsigned TIA_OP_WIDTH = 5;

    typedef logic [TIA_OP_WIDTH-1:0] tia_op_t;

    localparam tia_op_t TIA_OP_NOP   = 5'd0;
    localparam tia_op_t TIA_OP_ADD   = 5'd1;
    localparam tia_op_t TIA_OP_SUB   = 5'd2;
    localparam tia_op_t TIA_OP_AND   = 5'd3;
    localparam tia_op_t TIA_OP_OR    = 5'd4;
    localparam tia_op_t TIA_OP_XOR   = 5'd5;
    localparam tia_op_t TIA_OP_LMUL  = 5'd8;
    localparam tia_op_t TIA_OP_SHMUL = 5'd9;
    localparam tia_op_t TIA_OP_UHMUL = 5'd10;
    localparam tia_op_t TIA_OP_HALT  = 5'd31;

    typedef enum logic {
        LatSingleCycle,
        LatMultiply
    } lat_class_e;

    localparam int unsigned DefaultMultiplyLatency = 3;

endpackage

// File: rtl/integer_retirement_scoreboard_if.sv
// Trigger-stage request/response bundle between issue logic and the scoreboard.
interface integer_retirement_scoreboard_if #(
    parameter int unsigned MAX_LATENCY      = 3,
    parameter int unsigned NUM_RETIRE_PORTS = 1
);
    import integer_retirement_scoreboard_pkg::*;

    localparam int unsigned CntW = $clog2(NUM_RETIRE_PORTS + 1);
    localparam int unsigned IfW  = $clog2(MAX_LATENCY * NUM_RETIRE_PORTS + 1);

    tia_op_t           triggered_instruction_op;
    logic              trigger_valid;
    logic              pipeline_stall;
    logic              flush;
    logic              collision;
    logic              issue;
    logic [CntW-1:0]   retiring_count;
    logic [IfW-1:0]    in_flight_count;

    modport master (
        output triggered_instruction_op, trigger_valid, pipeline_stall, flush,
        input  collision, issue, retiring_count, in_flight_count
    );

    modport slave (
        input  triggered_instruction_op, trigger_valid, pipeline_stall, flush,
        output collision, issue, retiring_count, in_flight_count
    );

endinterface

// File: rtl/integer_latency_decoder.sv
// Opcode-to-retirement-latency decode; multiplies are the only multi-cycle class.
module integer_latency_decoder
    import integer_retirement_scoreboard_pkg::*;
#(
    parameter int unsigned MULTIPLY_LATENCY = DefaultMultiplyLatency,
    parameter int unsigned LatW             = 2
) (
    input  tia_op_t         op_i,
    output logic [LatW-1:0] latency_o
);

    lat_class_e lat_class;

    // Classify the opcode; everything that is not a multiply (NOP/HALT included) is single-cycle.
    always_comb begin
        lat_class = LatSingleCycle;
        case (op_i)
            TIA_OP_LMUL, TIA_OP_SHMUL, TIA_OP_UHMUL: lat_class = LatMultiply;
            default:                                 lat_class = LatSingleCycle;
        endcase
    end

    assign latency_o = (lat_class == LatMultiply) ? LatW'(MULTIPLY_LATENCY) : LatW'(1);

endmodule

// File: rtl/integer_retirement_scoreboard.sv
// Retirement-port scoreboard: tracks how many instructions retire in each future cycle and
// rejects (collision) a trigger whose retirement slot is already full.
module integer_retirement_scoreboard
    import integer_retirement_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_LATENCY      = 3,
    parameter int unsigned MULTIPLY_LATENCY = DefaultMultiplyLatency,
    parameter int unsigned NUM_RETIRE_PORTS = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    integer_retirement_scoreboard_if.slave    bus_io
);

    localparam int unsigned CntW = $clog2(NUM_RETIRE_PORTS + 1);
    localparam int unsigned IfW  = $clog2(MAX_LATENCY * NUM_RETIRE_PORTS + 1);
    localparam int unsigned LatW = $clog2(MAX_LATENCY + 1);
    localparam logic [CntW-1:0] PortsMax = CntW'(NUM_RETIRE_PORTS);

    // occ_q[j]: instructions retiring j cycles from now; the top slot only ever reads as zero.
    logic [CntW-1:0] occ_q [MAX_LATENCY+1];
    logic [CntW-1:0] occ_d [MAX_LATENCY+1];
    logic [LatW-1:0] lat;
    logic            collision;
    logic            issue;
    logic [IfW-1:0]  in_flight_sum;

    integer_latency_decoder #(
        .MULTIPLY_LATENCY (MULTIPLY_LATENCY),
        .LatW             (LatW)
    ) u_latency_decoder (
        .op_i      (bus_io.triggered_instruction_op),
        .latency_o (lat)
    );

    // Slot check and accept decision; reset gating keeps outputs quiet before occ is defined.
    always_comb begin
        collision = bus_io.trigger_valid & ~reset & (occ_q[lat] >= PortsMax);
        issue     = bus_io.trigger_valid & ~collision & ~bus_io.pipeline_stall
                  & ~bus_io.flush & ~reset;
    end

    // Advance the table one cycle and drop an accepted request into slot L-1.
    always_comb begin
        for (int j = 0; j <= MAX_LATENCY; j++) begin
            occ_d[j] = '0;
        end
        for (int j = 0; j < MAX_LATENCY; j++) begin
            occ_d[j] = occ_q[j+1] + CntW'(issue && (lat == LatW'(j + 1)));
        end
    end

    // State update: reset and flush squash everything, stall freezes the table.
    always_ff @(posedge clock) begin
        if (reset || bus_io.flush) begin
            for (int j = 0; j <= MAX_LATENCY; j++) begin
                occ_q[j] <= '0;
            end
        end else if (!bus_io.pipeline_stall) begin
            occ_q <= occ_d;
        end
    end

    // Reservations retiring in later cycles.
    always_comb begin
        in_flight_sum = '0;
        for (int j = 1; j <= MAX_LATENCY; j++) begin
            in_flight_sum = in_flight_sum + IfW'(occ_q[j]);
        end
    end

    assign bus_io.collision       = collision;
    assign bus_io.issue           = issue;
    assign bus_io.retiring_count  = occ_q[0];
    assign bus_io.in_flight_count = in_flight_sum;

    // No retirement slot may ever be oversubscribed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int j = 0; j <= MAX_LATENCY; j++) begin
                assert (int'(occ_q[j]) <= int'(NUM_RETIRE_PORTS));
            end
        end
    end

endmodule

// File: tb/tb_integer_retirement_scoreboard.sv
// Scoreboard bench: two scoreboards (1 and 2 retire ports) share directed and random
// stimulus; a per-instruction countdown model predicts every cycle's outputs.
module tb_integer_retirement_scoreboard;
    import integer_retirement_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    integer_retirement_scoreboard_if #(.MAX_LATENCY(3), .NUM_RETIRE_PORTS(1)) bus0 ();
    integer_retirement_scoreboard_if #(.MAX_LATENCY(3), .NUM_RETIRE_PORTS(2)) bus1 ();

    integer_retirement_scoreboard #(
        .MAX_LATENCY (3), .MULTIPLY_LATENCY (3), .NUM_RETIRE_PORTS (1)
    ) u_dut0 (
        .clock (clk), .reset (rst), .bus_io (bus0)
    );

    integer_retirement_scoreboard #(
        .MAX_LATENCY (3), .MULTIPLY_LATENCY (3), .NUM_RETIRE_PORTS (2)
    ) u_dut1 (
        .clock (clk), .reset (rst), .bus_io (bus1)
    );

    typedef struct packed {
        logic       coll;
        logic       iss;
        logic [7:0] ret;
        logic [7:0] inf;
    } exp_t;

    // One entry per in-flight instruction: rem = cycles until it retires.
    typedef struct {
        int dut;
        int rem;
    } res_t;

    res_t    pend[$];
    exp_t    exp_q0[$];
    exp_t    exp_q1[$];
    exp_t    mon_e;
    int      checks = 0;
    int      errors = 0;
    tia_op_t cur_op;
    logic    cur_v, cur_s, cur_f, cur_r;
    logic [1:0] cur_iss;

    function automatic int lat_of(input tia_op_t op);
        if (op == TIA_OP_LMUL || op == TIA_OP_SHMUL || op == TIA_OP_UHMUL) return 3;
        return 1;
    endfunction

    function automatic int count_rem(input int d, input int r);
        int n = 0;
        foreach (pend[i]) if (pend[i].dut == d && pend[i].rem == r) n++;
        return n;
    endfunction

    function automatic int count_inflight(input int d);
        int n = 0;
        foreach (pend[i]) if (pend[i].dut == d && pend[i].rem > 0) n++;
        return n;
    endfunction

    function automatic exp_t model_eval(input int d);
        exp_t e;
        int   nrp = (d == 0) ? 1 : 2;
        e.coll = cur_v && !cur_r && (count_rem(d, lat_of(cur_op)) >= nrp);
        e.iss  = cur_v && !e.coll && !cur_s && !cur_f && !cur_r;
        e.ret  = 8'(count_rem(d, 0));
        e.inf  = 8'(count_inflight(d));
        return e;
    endfunction

    function automatic void model_step(input int d);
        res_t nq[$];
        res_t r;
        if (!(cur_r || cur_f) && cur_s) return;
        foreach (pend[i]) begin
            if (pend[i].dut != d) nq.push_back(pend[i]);
            else if (!(cur_r || cur_f) && pend[i].rem > 0) begin
                r.dut = d;
                r.rem = pend[i].rem - 1;
                nq.push_back(r);
            end
        end
        if (!(cur_r || cur_f) && cur_iss[d]) begin
            r.dut = d;
            r.rem = lat_of(cur_op) - 1;
            nq.push_back(r);
        end
        pend = nq;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Apply inputs for one cycle and queue the predicted response.
    task automatic set_in(input tia_op_t op, input logic v, input logic s, input logic f,
                          input logic r);
        exp_t e0, e1;
        cur_op = op; cur_v = v; cur_s = s; cur_f = f; cur_r = r;
        rst = r;
        bus0.triggered_instruction_op = op; bus0.trigger_valid = v;
        bus0.pipeline_stall = s;            bus0.flush = f;
        bus1.triggered_instruction_op = op; bus1.trigger_valid = v;
        bus1.pipeline_stall = s;            bus1.flush = f;
        e0 = model_eval(0);
        e1 = model_eval(1);
        cur_iss = {e1.iss, e0.iss};
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            set_in(TIA_OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    function automatic tia_op_t rand_op();
        case ($urandom_range(0, 7))
            0: return TIA_OP_NOP;
            1: return TIA_OP_ADD;
            2: return TIA_OP_SUB;
            3: return TIA_OP_XOR;
            4: return TIA_OP_LMUL;
            5: return TIA_OP_SHMUL;
            6: return TIA_OP_UHMUL;
            default: return TIA_OP_HALT;
        endcase
    endfunction

    // Monitor: every cycle with a queued prediction is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            mon_e = exp_q0.pop_front();
            chk("d0_collision", 32'(bus0.collision), 32'(mon_e.coll));
            chk("d0_issue", 32'(bus0.issue), 32'(mon_e.iss));
            chk("d0_retiring", 32'(bus0.retiring_count), 32'(mon_e.ret));
            chk("d0_in_flight", 32'(bus0.in_flight_count), 32'(mon_e.inf));
        end
        if (exp_q1.size() > 0) begin
            mon_e = exp_q1.pop_front();
            chk("d1_collision", 32'(bus1.collision), 32'(mon_e.coll));
            chk("d1_issue", 32'(bus1.issue), 32'(mon_e.iss));
            chk("d1_retiring", 32'(bus1.retiring_count), 32'(mon_e.ret));
            chk("d1_in_flight", 32'(bus1.in_flight_count), 32'(mon_e.inf));
        end
    end

    initial begin
        rst = 1'b1;
        bus0.triggered_instruction_op = TIA_OP_NOP; bus0.trigger_valid = 1'b0;
        bus0.pipeline_stall = 1'b0;                 bus0.flush = 1'b0;
        bus1.triggered_instruction_op = TIA_OP_NOP; bus1.trigger_valid = 1'b0;
        bus1.pipeline_stall = 1'b0;                 bus1.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with a live request: outputs stay quiet.
        set_in(TIA_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_collision", 32'(bus0.collision), 0);
        chk("rst_issue", 32'(bus0.issue), 0);
        chk("rst_retiring", 32'(bus0.retiring_count), 0);
        chk("rst_in_flight", 32'(bus0.in_flight_count), 0);
        tick();
        idle(2);

        // LMUL then ADD two cycles later lands in the same slot.
        set_in(TIA_OP_LMUL, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s30_lmul_issue", 32'(bus0.issue), 1);
        tick();
        set_in(TIA_OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        set_in(TIA_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s30_add_collision", 32'(bus0.collision), 1);
        chk("s30_add_no_issue", 32'(bus0.issue), 0);
        chk("s34_two_ports_no_collision", 32'(bus1.collision), 0);
        chk("s34_two_ports_issue", 32'(bus1.issue), 1);
        tick();
        set_in(TIA_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s30_retry_issue", 32'(bus0.issue), 1);
        chk("s30_lmul_retires", 32'(bus0.retiring_count), 1);
        chk("s34_two_retire", 32'(bus1.retiring_count), 2);
        tick();
        idle(4);

        // Back-to-back single-cycle ops never collide.
        for (int i = 0; i <= 10; i++) begin
            set_in((i < 10) ? TIA_OP_ADD : TIA_OP_NOP, i < 10, 1'b0, 1'b0, 1'b0);
            if (i < 10) chk("s31_no_collision", 32'(bus0.collision), 0);
            if (i >= 1) chk("s31_retiring", 32'(bus0.retiring_count), 1);
            tick();
        end
        idle(4);

        // A stall shifts the multiply's slot by one cycle.
        set_in(TIA_OP_LMUL, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_in(TIA_OP_NOP, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        set_in(TIA_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s32_add_issue", 32'(bus0.issue), 1);
        tick();
        set_in(TIA_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s32_add_collision", 32'(bus0.collision), 1);
        tick();
        set_in(TIA_OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s32_lmul_retires", 32'(bus0.retiring_count), 1);
        chk("s32_in_flight", 32'(bus0.in_flight_count), 0);
        tick();
        idle(4);

        // Flush squashes the multiply.
        set_in(TIA_OP_LMUL, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_in(TIA_OP_NOP, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        set_in(TIA_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s33_in_flight_cleared", 32'(bus0.in_flight_count), 0);
        chk("s33_add_issue", 32'(bus0.issue), 1);
        tick();
        set_in(TIA_OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s33_only_add_retires", 32'(bus0.retiring_count), 1);
        tick();
        idle(4);

        // Mid-operation reset drops the multiply.
        set_in(TIA_OP_LMUL, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        set_in(TIA_OP_NOP, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        set_in(TIA_OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("s35_in_flight_cleared", 32'(bus0.in_flight_count), 0);
        chk("s35_retiring_cleared", 32'(bus0.retiring_count), 0);
        chk("s35_add_issue", 32'(bus0.issue), 1);
        tick();
        set_in(TIA_OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("s35_add_retires", 32'(bus0.retiring_count), 1);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            set_in(rand_op(), $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
            tick();
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
